// File: rtl/fir_pkg.sv
// Shared types and default widths for the sequential FIR MAC filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_NTAPS  = 4;

endpackage

// File: rtl/fir_sample_window.sv
// Tapped delay line holding the NTAPS most recent samples; slot 0 (low bits) is newest.
module fir_sample_window
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NTAPS  = DEF_NTAPS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en,
  input  logic [DATA_W-1:0]       sample,
  output logic [NTAPS*DATA_W-1:0] window
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      window <= '0;
    end else if (en) begin
      window <= {window[(NTAPS-1)*DATA_W-1:0], sample};
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one shared multiplier walks the taps, one MAC per enabled cycle,
// then the saturated sum is held on a valid/ready output until taken.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int NTAPS  = DEF_NTAPS,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = DATA_W + COEF_W + $clog2(NTAPS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clk_en_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [DATA_W-1:0]        s_data_i,
  input  logic                     coef_we_i,
  input  logic [$clog2(NTAPS)-1:0] coef_addr_i,
  input  logic [COEF_W-1:0]        coef_data_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [OUT_W-1:0]         m_data_o,
  output logic                     busy_o
);

  localparam int TAP_W  = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + TAP_W;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    lo = ~hi;
    if (v > hi) begin
      sat_out = hi[OUT_W-1:0];
    end else if (v < lo) begin
      sat_out = lo[OUT_W-1:0];
    end else begin
      sat_out = v[OUT_W-1:0];
    end
  endfunction

  fir_state_e              state;
  fir_state_e              state_nx;
  logic [TAP_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [COEF_W-1:0] coef [NTAPS];
  logic [NTAPS*DATA_W-1:0] window;
  logic signed [DATA_W-1:0] tap_sample;
  logic signed [COEF_W-1:0] tap_coef;
  logic signed [PROD_W-1:0] prod_p0;
  logic                    vld_p1;
  logic                    take;
  logic                    last_tap;
  logic                    coef_ok;

  assign s_ready_o  = (state == IDLE) & ~rst_i;
  assign busy_o     = (state == MAC);
  assign take       = s_valid_i & s_ready_o & clk_en_i;
  assign last_tap   = (int'(idx) == NTAPS - 1);
  // Coefficients are frozen while a sum is being accumulated.
  assign coef_ok    = coef_we_i & clk_en_i & (state != MAC) & (int'(coef_addr_i) < NTAPS);

  fir_sample_window #(
    .DATA_W(DATA_W),
    .NTAPS (NTAPS)
  ) u_window (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (take),
    .sample(s_data_i),
    .window(window)
  );

  // Stage p0: the single shared multiplier for the tap selected by idx
  assign tap_sample = window[int'(idx)*DATA_W +: DATA_W];
  assign tap_coef   = coef[idx];
  assign prod_p0    = PROD_W'(tap_sample) * PROD_W'(tap_coef);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = MAC;
      MAC:     if (clk_en_i && last_tap) state_nx = OUT;
      OUT:     if (clk_en_i && m_valid_o && m_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p1: accumulate, then one extra OUT cycle registers the saturated result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc       <= '0;
      idx       <= '0;
      vld_p1    <= 1'b0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        coef[k] <= '0;
      end
    end else if (clk_en_i) begin
      case (state)
        IDLE: begin
          if (take) begin
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc    <= acc + ACC_W'(prod_p0);
          idx    <= idx + 1'b1;
          vld_p1 <= last_tap;
        end
        OUT: begin
          if (vld_p1) begin
            m_data_o  <= sat_out(acc >>> SHIFT);
            m_valid_o <= 1'b1;
            vld_p1    <= 1'b0;
          end else if (m_valid_o && m_ready_i) begin
            m_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase
      if (coef_ok) begin
        coef[coef_addr_i] <= coef_data_i;
      end
    end
  end

endmodule
